prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 102 ++++++++++
 tb/tb_prod_accum.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Group accumulator for signed 8-bit products: sums len products (0 = 16) and
// holds the sum until taken downstream. PROD_ACCUM_SAT_EN enables saturating adds and ovf.
module prod_accum #(
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [7:0]       prod,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              len,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]              cnt_q, cnt_d, len_q, len_d;
  logic [4:0]              len_in, tgt, cnt_inc;
  logic                    ovf_q, ovf_d, rdy_q;
  logic                    accept;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] add_res;
  logic                    clamp;

  // rdy_q keeps in_ready low until the first edge after reset is released
  assign in_ready  = rdy_q && (state_q != DONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  assign len_in  = {(len == 4'd0), len};
  assign tgt     = (state_q == IDLE) ? len_in : len_q;
  assign cnt_inc = cnt_q + 5'd1;

  // One guard bit makes the signed overflow visible as a top-two-bit mismatch
  assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){prod[7]}}, prod};

`ifdef PROD_ACCUM_SAT_EN
  always_comb begin
    clamp   = sum[ACC_W] ^ sum[ACC_W-1];
    add_res = sum[ACC_W-1:0];
    if (clamp)
      add_res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign clamp   = 1'b0;
  assign add_res = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d   = add_res;
          ovf_d   = ovf_q | clamp;
          cnt_d   = cnt_inc;
          if (state_q == IDLE) len_d = len_in;
          state_d = (cnt_inc == tgt) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: ACC_W=12 instance for the main scenarios,
// ACC_W=8 instance for the overflow scenario.
module tb_prod_accum;

  typedef struct {int acc; int ovf;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [7:0]  prod;
  logic               in_valid, in_ready, out_valid, out_ready, ovf;
  logic [3:0]         len;
  logic signed [11:0] acc_out;

  logic signed [7:0]  p8;
  logic               v8, rdy8, ov8, r8, ovf8;
  logic [3:0]         l8;
  logic signed [7:0]  acc8;

  int checks = 0;
  int errors = 0;
  exp_t q12[$];
  exp_t q8[$];

  prod_accum #(.ACC_W(12)) dut (
    .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_ready(in_ready),
    .len(len), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  prod_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .prod(p8), .in_valid(v8), .in_ready(rdy8),
    .len(l8), .acc_out(acc8), .out_valid(ov8), .out_ready(r8), .ovf(ovf8)
  );

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Monitors: a result is consumed on every cycle where valid and ready meet
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (q12.size() == 0) chk("unexpected_out12", 1, 0);
      else begin
        e = q12.pop_front();
        chk("acc12", int'(acc_out), e.acc);
        chk("ovf12", int'(ovf), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov8 && r8) begin
      if (q8.size() == 0) chk("unexpected_out8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("acc8", int'(acc8), e.acc);
        chk("ovf8", int'(ovf8), e.ovf);
      end
    end
  end

  task automatic push(input int a, input int o);
    exp_t e;
    e.acc = a;
    e.ovf = o;
    q12.push_back(e);
  endtask

  task automatic send(input int p, input int l);
    int n;
    prod = 8'(p);
    len = 4'(l);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e8;
    prod = '0; in_valid = 1'b0; len = '0; out_ready = 1'b1;
    p8 = '0; v8 = 1'b0; l8 = '0; r8 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);

    // ACC_W=8, four products of 64
`ifdef PROD_ACCUM_SAT_EN
    e8.acc = 127; e8.ovf = 1;
`else
    e8.acc = 0;   e8.ovf = 0;
`endif
    q8.push_back(e8);
    @(posedge clk); #1 v8 = 1'b1; p8 = 8'sd64; l8 = 4'd4;
    repeat (4) @(posedge clk);
    #1 v8 = 1'b0;
    repeat (2) @(posedge clk); #1;

    // len=3: 5, -3, 10
    push(12, 0);
    send(5, 3);
    send(-3, 3);
    @(negedge clk);
    chk("running_acc", int'(acc_out), 2);
    chk("mid_group_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    send(10, 3);
    @(negedge clk);
    chk("latency_out_valid", int'(out_valid), 1);
    chk("latency_acc", int'(acc_out), 12);
    @(posedge clk); #1;

    // len=0 means 16: 16 x 127 then 16 x -128
    push(2032, 0);
    push(-2048, 0);
    for (int i = 0; i < 16; i++) begin
      send(127, 0);
      if (i == 14) begin
        @(negedge clk);
        chk("len16_not_done_at_15", int'(out_valid), 0);
        chk("len16_acc_at_15", int'(acc_out), 1905);
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 16; i++) send(-128, 0);
    repeat (2) @(posedge clk); #1;

    // Back-pressure: result held, input stalled, then fresh group
    out_ready = 1'b0;
    push(15, 0);
    push(99, 0);
    send(7, 2);
    send(8, 2);
    prod = 8'sd99; len = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_acc", int'(acc_out), 15);
      chk("stall_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_hs_in_ready", int'(in_ready), 1);
    chk("after_hs_acc", int'(acc_out), 0);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset mid-group abandons the partial sum
    send(1, 4);
    send(2, 4);
    @(negedge clk);
    chk("partial_acc", int'(acc_out), 3);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_acc", int'(acc_out), 0);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    push(-9, 0);
    send(-9, 1);
    repeat (2) @(posedge clk); #1;

    // len latched on first accept
    push(10, 0);
    send(4, 2);
    send(6, 5);
    @(negedge clk);
    chk("len_latched_done", int'(out_valid), 1);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("q12_drained", q12.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
